ptp_slave_exchange: RTL and testbench

Slave-side PTP two-step exchange sequencer that feeds the cycle-synchronisation/master-clock block. It watches parsed PTP messages from the receive path, captures master origin time t1, and marks local arrival t2. It then launches a Delay_Req, captures its egress time t3, and captures master receive time t4 from the matching Delay_Resp. When all four timestamps are consistent it fires the single-cycle `status_ok` that triggers the offset computation downstream.

---
 rtl/ptp_slave_exchange.sv | 157 +++++++++++++++
 tb/tb_ptp_slave_exchange.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_slave_exchange.sv
// Slave-side PTP two-step exchange sequencer: captures t1/t3/t4, marks t2, issues
// Delay_Req and reports a complete, consistent exchange with a single status_ok.
module ptp_slave_exchange #(
    parameter int unsigned TIMEOUT_CYC = 125000,
    parameter int unsigned CYC_MAX     = 124999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_or_s,
    input  logic        rx_msg_valid,
    input  logic [3:0]  rx_msg_type,
    input  logic [15:0] rx_seq_id,
    input  logic [47:0] rx_ts_field,
    input  logic        tx_done,
    input  logic [47:0] tx_ts,
    output logic        send_delay_req,
    output logic [15:0] delay_req_seq,
    output logic        ts_2_record,
    output logic        ts_1_valid,
    output logic        ts_3_valid,
    output logic        ts_4_valid,
    output logic [47:0] ts_1,
    output logic [47:0] ts_3,
    output logic [47:0] ts_4,
    output logic        status_ok,
    output logic        timeout,
    output logic        fmt_err,
    output logic [15:0] exch_cnt,
    output logic [2:0]  state_dbg
);
    // Every input and output strobe is a single-cycle valid with no ready/back-pressure:
    // inputs are sampled on the edge that ends the cycle they are high, outputs are registered.
    typedef enum logic [2:0] {IDLE, REQ, WAIT_TX, WAIT_RESP, DONE} state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state, state_nx;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nx;
    logic [15:0]   seq_cnt;
    logic          done_wait, done_wait_nx;
    logic          is_sync, is_resp, cyc_ok, tmo_hit;
    logic          ts_1_ld, ts_3_ld, ts_4_ld;
    logic          req_nx, status_nx, timeout_nx, fmt_err_nx;

    assign is_sync   = rx_msg_valid && (rx_msg_type == 4'h0);
    assign is_resp   = rx_msg_valid && (rx_msg_type == 4'h9);
    assign cyc_ok    = 32'(rx_ts_field[16:0]) <= CYC_MAX;
    assign tmo_hit   = tmo_cnt == TW'(TIMEOUT_CYC - 1);
    assign state_dbg = state;

    always_comb begin
        state_nx     = state;
        tmo_cnt_nx   = tmo_cnt;
        done_wait_nx = 1'b0;
        ts_1_ld      = 1'b0;
        ts_3_ld      = 1'b0;
        ts_4_ld      = 1'b0;
        req_nx       = 1'b0;
        status_nx    = 1'b0;
        timeout_nx   = 1'b0;
        fmt_err_nx   = 1'b0;
        if (m_or_s) begin
            state_nx = IDLE;
        end else if (is_sync && cyc_ok) begin
            // A valid Sync always (re)starts the exchange, beating tx_done or Delay_Resp.
            ts_1_ld  = 1'b1;
            state_nx = REQ;
        end else begin
            fmt_err_nx = is_sync;
            case (state)
                IDLE: ;
                REQ: begin
                    req_nx     = 1'b1;
                    tmo_cnt_nx = '0;
                    state_nx   = WAIT_TX;
                end
                WAIT_TX: begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                    if (tmo_hit) begin
                        timeout_nx = 1'b1;
                        state_nx   = IDLE;
                    end else if (tx_done) begin
                        ts_3_ld  = 1'b1;
                        state_nx = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                    if (tmo_hit) begin
                        timeout_nx = 1'b1;
                        state_nx   = IDLE;
                    end else if (is_resp && rx_seq_id == delay_req_seq) begin
                        if (cyc_ok) begin
                            ts_4_ld  = 1'b1;
                            state_nx = DONE;
                        end else begin
                            fmt_err_nx = 1'b1;
                            state_nx   = IDLE;
                        end
                    end
                end
                DONE: begin
                    // Extra settle cycle so ts_4 is stable downstream before status_ok.
                    if (done_wait) begin
                        status_nx = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        done_wait_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            done_wait      <= 1'b0;
            seq_cnt        <= '0;
            send_delay_req <= 1'b0;
            delay_req_seq  <= '0;
            ts_2_record    <= 1'b0;
            ts_1_valid     <= 1'b0;
            ts_3_valid     <= 1'b0;
            ts_4_valid     <= 1'b0;
            ts_1           <= '0;
            ts_3           <= '0;
            ts_4           <= '0;
            status_ok      <= 1'b0;
            timeout        <= 1'b0;
            fmt_err        <= 1'b0;
            exch_cnt       <= '0;
        end else begin
            state          <= state_nx;
            tmo_cnt        <= tmo_cnt_nx;
            done_wait      <= done_wait_nx;
            send_delay_req <= req_nx;
            ts_2_record    <= ts_1_ld;
            ts_1_valid     <= ts_1_ld;
            ts_3_valid     <= ts_3_ld;
            ts_4_valid     <= ts_4_ld;
            status_ok      <= status_nx;
            timeout        <= timeout_nx;
            fmt_err        <= fmt_err_nx;
            if (req_nx) begin
                delay_req_seq <= seq_cnt;
                seq_cnt       <= seq_cnt + 16'd1;
            end
            if (ts_1_ld)   ts_1     <= rx_ts_field;
            if (ts_3_ld)   ts_3     <= tx_ts;
            if (ts_4_ld)   ts_4     <= rx_ts_field;
            if (status_nx) exch_cnt <= exch_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_ptp_slave_exchange.sv
// Directed bench for ptp_slave_exchange: nominal, wrong seq, timeout, bad format,
// restart, master mode and mid-exchange reset, with hand-computed expectations.
module tb_ptp_slave_exchange;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_or_s = 1'b0;
    logic        rx_msg_valid = 1'b0;
    logic [3:0]  rx_msg_type = '0;
    logic [15:0] rx_seq_id = '0;
    logic [47:0] rx_ts_field = '0;
    logic        tx_done = 1'b0;
    logic [47:0] tx_ts = '0;
    logic        send_delay_req, ts_2_record, ts_1_valid, ts_3_valid, ts_4_valid;
    logic        status_ok, timeout, fmt_err;
    logic [15:0] delay_req_seq, exch_cnt;
    logic [47:0] ts_1, ts_3, ts_4;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_t1v, n_t2r, n_t3v, n_t4v, n_req, n_ok, n_to, n_fmt;
    int t1v_cyc, t2r_cyc, t3v_cyc, t4v_cyc, req_cyc, ok_cyc, to_cyc, fmt_cyc;
    int s_at, t_at, r_at;

    ptp_slave_exchange #(.TIMEOUT_CYC(100), .CYC_MAX(124999)) dut (
        .clk(clk), .reset(reset), .m_or_s(m_or_s),
        .rx_msg_valid(rx_msg_valid), .rx_msg_type(rx_msg_type), .rx_seq_id(rx_seq_id),
        .rx_ts_field(rx_ts_field), .tx_done(tx_done), .tx_ts(tx_ts),
        .send_delay_req(send_delay_req), .delay_req_seq(delay_req_seq),
        .ts_2_record(ts_2_record), .ts_1_valid(ts_1_valid), .ts_3_valid(ts_3_valid),
        .ts_4_valid(ts_4_valid), .ts_1(ts_1), .ts_3(ts_3), .ts_4(ts_4),
        .status_ok(status_ok), .timeout(timeout), .fmt_err(fmt_err),
        .exch_cnt(exch_cnt), .state_dbg(state_dbg)
    );

    // clock / cycle index
    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // strobe monitor, sampled 1 time unit after the active edge
    always @(posedge clk) begin
        #1;
        if (ts_1_valid)     begin n_t1v++; t1v_cyc = cyc; end
        if (ts_2_record)    begin n_t2r++; t2r_cyc = cyc; end
        if (ts_3_valid)     begin n_t3v++; t3v_cyc = cyc; end
        if (ts_4_valid)     begin n_t4v++; t4v_cyc = cyc; end
        if (send_delay_req) begin n_req++; req_cyc = cyc; end
        if (status_ok)      begin n_ok++;  ok_cyc  = cyc; end
        if (timeout)        begin n_to++;  to_cyc  = cyc; end
        if (fmt_err)        begin n_fmt++; fmt_cyc = cyc; end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_t1v = 0; n_t2r = 0; n_t3v = 0; n_t4v = 0;
        n_req = 0; n_ok = 0; n_to = 0; n_fmt = 0;
        t1v_cyc = -1; t2r_cyc = -1; t3v_cyc = -1; t4v_cyc = -1;
        req_cyc = -1; ok_cyc = -1; to_cyc = -1; fmt_cyc = -1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // driver tasks: called at a negedge, hold the strobe for exactly one cycle
    task automatic send_msg(input logic [3:0] t, input logic [15:0] s, input logic [47:0] ts,
                            output int at);
        rx_msg_valid = 1'b1; rx_msg_type = t; rx_seq_id = s; rx_ts_field = ts; at = cyc;
        @(negedge clk);
        rx_msg_valid = 1'b0;
    endtask

    task automatic pulse_tx(input logic [47:0] ts, output int at);
        tx_done = 1'b1; tx_ts = ts; at = cyc;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        clear_counts();
        wait_cycles(3);
        reset = 1'b0;
        check_eq("rst_state", state_dbg, 0);
        check_eq("rst_ts_1", ts_1, 0);
        check_eq("rst_seq", delay_req_seq, 0);
        check_eq("rst_exch", exch_cnt, 0);
        check_eq("rst_strobes", {send_delay_req, ts_1_valid, status_ok, timeout, fmt_err}, 0);

        // nominal exchange: Sync @s, tx_done @s+10, Delay_Resp @s+30
        clear_counts();
        send_msg(4'h0, 16'd0, 48'h0000_0002_0010, s_at);
        wait_cycles(9);
        pulse_tx(48'h0000_0002_0200, t_at);
        wait_cycles(19);
        send_msg(4'h9, 16'd0, 48'h0000_0002_0300, r_at);
        wait_cycles(5);
        check_eq("nom_t1v_cyc", t1v_cyc, s_at + 1);
        check_eq("nom_t2r_cyc", t2r_cyc, s_at + 1);
        check_eq("nom_req_cyc", req_cyc, s_at + 2);
        check_eq("nom_t3v_cyc", t3v_cyc, t_at + 1);
        check_eq("nom_t4v_cyc", t4v_cyc, r_at + 1);
        check_eq("nom_ok_cyc", ok_cyc, r_at + 3);
        check_eq("nom_n_ok", n_ok, 1);
        check_eq("nom_ts_1", ts_1, 48'h0000_0002_0010);
        check_eq("nom_ts_3", ts_3, 48'h0000_0002_0200);
        check_eq("nom_ts_4", ts_4, 48'h0000_0002_0300);
        check_eq("nom_seq", delay_req_seq, 0);
        check_eq("nom_exch", exch_cnt, 1);
        check_eq("nom_state", state_dbg, 0);

        // wrong sequence id is ignored, matching one completes
        clear_counts();
        send_msg(4'h0, 16'd0, 48'h0000_0005_0100, s_at);
        wait_cycles(3);
        pulse_tx(48'h0000_0005_0500, t_at);
        wait_cycles(2);
        send_msg(4'h9, 16'd5, 48'h0000_0005_0600, r_at);
        wait_cycles(3);
        check_eq("wseq_seq", delay_req_seq, 1);
        check_eq("wseq_no_t4v", n_t4v, 0);
        check_eq("wseq_state", state_dbg, 3);
        send_msg(4'h9, 16'd1, 48'h0000_0005_0700, r_at);
        wait_cycles(5);
        check_eq("wseq_n_ok", n_ok, 1);
        check_eq("wseq_ts_4", ts_4, 48'h0000_0005_0700);
        check_eq("wseq_exch", exch_cnt, 2);

        // timeout 100 cycles after REQ exit (send_delay_req cycle)
        clear_counts();
        send_msg(4'h0, 16'd0, 48'h0000_0006_0040, s_at);
        wait_cycles(3);
        pulse_tx(48'h0000_0006_0080, t_at);
        wait_cycles(110);
        check_eq("to_n", n_to, 1);
        check_eq("to_cyc", to_cyc, req_cyc + 100);
        check_eq("to_no_ok", n_ok, 0);
        check_eq("to_state", state_dbg, 0);
        check_eq("to_seq", delay_req_seq, 2);
        check_eq("to_ts_3_kept", ts_3, 48'h0000_0006_0080);

        // bad format Sync: cyc = 125000
        clear_counts();
        send_msg(4'h0, 16'd0, 48'h0000_0007_E848, s_at);
        wait_cycles(5);
        check_eq("fmt_n", n_fmt, 1);
        check_eq("fmt_cyc", fmt_cyc, s_at + 1);
        check_eq("fmt_no_t1v", n_t1v, 0);
        check_eq("fmt_no_req", n_req, 0);
        check_eq("fmt_ts_1_kept", ts_1, 48'h0000_0006_0040);
        check_eq("fmt_state", state_dbg, 0);

        // restart during WAIT_RESP; old seq ignored afterwards
        clear_counts();
        send_msg(4'h0, 16'd0, 48'h0000_0008_0010, s_at);
        wait_cycles(3);
        pulse_tx(48'h0000_0008_0020, t_at);
        wait_cycles(3);
        send_msg(4'h0, 16'd0, 48'h0000_0009_0010, s_at);
        wait_cycles(3);
        check_eq("rst_ts_1_new", ts_1, 48'h0000_0009_0010);
        check_eq("rs_seq", delay_req_seq, 4);
        check_eq("rs_n_req", n_req, 2);
        pulse_tx(48'h0000_0009_0020, t_at);
        wait_cycles(2);
        send_msg(4'h9, 16'd3, 48'h0000_0009_0030, r_at);
        wait_cycles(3);
        check_eq("rs_old_seq_ign", n_t4v, 0);
        send_msg(4'h9, 16'd4, 48'h0000_0009_0040, r_at);
        wait_cycles(5);
        check_eq("rs_n_ok", n_ok, 1);
        check_eq("rs_exch", exch_cnt, 3);

        // master mode mid-WAIT_TX
        clear_counts();
        send_msg(4'h0, 16'd0, 48'h0000_000A_0010, s_at);
        wait_cycles(3);
        check_eq("ms_in_wait_tx", state_dbg, 2);
        m_or_s = 1'b1;
        @(negedge clk);
        check_eq("ms_idle", state_dbg, 0);
        clear_counts();
        send_msg(4'h0, 16'd0, 48'h0000_000B_0010, s_at);
        pulse_tx(48'h0000_000B_0020, t_at);
        wait_cycles(10);
        check_eq("ms_no_strobes", n_t1v + n_t2r + n_t3v + n_t4v + n_req + n_ok + n_to + n_fmt, 0);
        check_eq("ms_state", state_dbg, 0);
        m_or_s = 1'b0;

        // reset mid-WAIT_RESP
        send_msg(4'h0, 16'd0, 48'h0000_000C_0010, s_at);
        wait_cycles(3);
        pulse_tx(48'h0000_000C_0020, t_at);
        wait_cycles(3);
        check_eq("rr_in_wait_resp", state_dbg, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rr_state", state_dbg, 0);
        check_eq("rr_ts", {ts_1, ts_3}, 0);
        check_eq("rr_ts_4", ts_4, 0);
        check_eq("rr_seq_exch", {delay_req_seq, exch_cnt}, 0);
        check_eq("rr_strobes", {send_delay_req, ts_2_record, ts_1_valid, ts_3_valid,
                                ts_4_valid, status_ok, timeout, fmt_err}, 0);
        clear_counts();
        send_msg(4'h0, 16'd0, 48'h0000_000D_0010, s_at);
        wait_cycles(3);
        check_eq("rr_seq_restart", delay_req_seq, 0);
        check_eq("rr_n_req", n_req, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
